// File: rtl/door_pkg.sv
// Shared types and constants for the door access controller.
// Holds the FSM state enum, default parameters and width helpers.
package door_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        UNLOCK  = 2'd2,
        LOCKOUT = 2'd3
    } door_state_e;

    localparam int DEF_CODE_LEN       = 4;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_UNLOCK_CYCLES  = 8;
    localparam int DEF_LOCKOUT_CYCLES = 16;

    function automatic int tries_width(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

    function automatic int timer_width(input int unlock_cycles, input int lockout_cycles);
        int longest;
        longest = (unlock_cycles > lockout_cycles) ? unlock_cycles : lockout_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter shared by the unlock and lockout windows.
// expire is registered and is high during the final cycle of a loaded window.
module door_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expire
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_s;
    logic             expire_r;

    // Next count: load wins, otherwise count down and park at zero
    always_comb begin
        count_s = count_r;
        if (load) begin
            count_s = load_value;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_s = count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_s = count_r;
        end
    end

    // Counter and registered expire flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r  <= {WIDTH{1'b0}};
            expire_r <= 1'b0;
        end else begin
            count_r  <= count_s;
            expire_r <= (count_s == {{(WIDTH-1){1'b0}}, 1'b1});
        end
    end

    assign expire = expire_r;

endmodule

// File: rtl/door_access_ctrl.sv
// Serial entry-code checker with attempt limiting, a timed unlock window
// and a timed lockout after too many consecutive wrong codes.
module door_access_ctrl
    import door_pkg::*;
#(
    parameter int CODE_LEN       = DEF_CODE_LEN,
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                cfg_we,
    input  logic [CODE_LEN-1:0]                 cfg_code,
    input  logic                                bit_valid,
    input  logic                                bit_in,
    output logic                                unlock,
    output logic                                attempt_fail,
    output logic                                locked_out,
    output logic [tries_width(MAX_TRIES)-1:0]   tries_left
);

    localparam int TRY_W = tries_width(MAX_TRIES);
    localparam int TMR_W = timer_width(UNLOCK_CYCLES, LOCKOUT_CYCLES);
    localparam int CNT_W = $clog2(CODE_LEN);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(CODE_LEN - 1);
    localparam logic [TRY_W-1:0] TRIES_MAX = TRY_W'(MAX_TRIES);
    localparam logic [TRY_W-1:0] TRY_ONE   = TRY_W'(1);
    localparam logic [TRY_W-1:0] TRY_ZERO  = {TRY_W{1'b0}};
    localparam logic [TMR_W-1:0] UNLOCK_LD = TMR_W'(UNLOCK_CYCLES);
    localparam logic [TMR_W-1:0] LOCK_LD   = TMR_W'(LOCKOUT_CYCLES);

    door_state_e         state_r;
    door_state_e         state_s;
    logic [CODE_LEN-1:0] shift_r;
    logic [CODE_LEN-1:0] shift_s;
    logic [CODE_LEN-1:0] code_r;
    logic [CODE_LEN-1:0] code_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic [TRY_W-1:0]    tries_r;
    logic [TRY_W-1:0]    tries_s;
    logic                fail_s;
    logic                tmr_load_s;
    logic [TMR_W-1:0]    tmr_value_s;
    logic                tmr_expire_s;
    logic                unlock_r;
    logic                locked_out_r;
    logic                attempt_fail_r;

    door_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load_s),
        .load_value (tmr_value_s),
        .expire     (tmr_expire_s)
    );

    // Next-state, datapath and timer-load decisions
    always_comb begin
        state_s     = state_r;
        shift_s     = shift_r;
        cnt_s       = cnt_r;
        code_s      = code_r;
        tries_s     = tries_r;
        fail_s      = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_value_s = {TMR_W{1'b0}};
        case (state_r)
            COLLECT: begin
                // A config write between entries takes priority; a bit in the same cycle is dropped
                if (cfg_we && (cnt_r == CNT_ZERO)) begin
                    code_s = cfg_code;
                end else if (bit_valid) begin
                    shift_s = {shift_r[CODE_LEN-2:0], bit_in};
                    if (cnt_r == LAST_BIT) begin
                        cnt_s   = CNT_ZERO;
                        state_s = CHECK;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            CHECK: begin
                if (shift_r == code_r) begin
                    state_s     = UNLOCK;
                    tries_s     = TRIES_MAX;
                    tmr_load_s  = 1'b1;
                    tmr_value_s = UNLOCK_LD;
                end else begin
                    fail_s = 1'b1;
                    if (tries_r <= TRY_ONE) begin
                        tries_s     = TRY_ZERO;
                        state_s     = LOCKOUT;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = LOCK_LD;
                    end else begin
                        tries_s = tries_r - TRY_ONE;
                        state_s = COLLECT;
                    end
                end
            end
            UNLOCK: begin
                if (tmr_expire_s) begin
                    state_s = COLLECT;
                end else begin
                    state_s = UNLOCK;
                end
            end
            LOCKOUT: begin
                if (tmr_expire_s) begin
                    tries_s = TRIES_MAX;
                    state_s = COLLECT;
                end else begin
                    state_s = LOCKOUT;
                end
            end
            default: begin
                state_s = COLLECT;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= COLLECT;
            shift_r        <= {CODE_LEN{1'b0}};
            code_r         <= {CODE_LEN{1'b0}};
            cnt_r          <= CNT_ZERO;
            tries_r        <= TRIES_MAX;
            unlock_r       <= 1'b0;
            locked_out_r   <= 1'b0;
            attempt_fail_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            shift_r        <= shift_s;
            code_r         <= code_s;
            cnt_r          <= cnt_s;
            tries_r        <= tries_s;
            unlock_r       <= (state_s == UNLOCK);
            locked_out_r   <= (state_s == LOCKOUT);
            attempt_fail_r <= fail_s;
        end
    end

    assign unlock       = unlock_r;
    assign locked_out   = locked_out_r;
    assign attempt_fail = attempt_fail_r;
    assign tries_left   = tries_r;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Self-checking bench for door_access_ctrl: directed scenarios plus randomized
// attempts, checked against an attempt-level model of code, tries and windows.
module tb_door_access_ctrl;

    localparam int CL = 4;
    localparam int MT = 3;
    localparam int UC = 8;
    localparam int LC = 16;

    logic          clk          = 1'b0;
    logic          reset        = 1'b0;
    logic          cfg_we       = 1'b0;
    logic [CL-1:0] cfg_code     = 4'b0000;
    logic          bit_valid    = 1'b0;
    logic          bit_in       = 1'b0;
    logic          unlock;
    logic          attempt_fail;
    logic          locked_out;
    logic [1:0]    tries_left;

    int            checks = 0;
    int            errors = 0;
    logic [CL-1:0] m_code  = 4'b0000;
    int            m_tries = MT;

    always #5 clk = ~clk;

    door_access_ctrl #(
        .CODE_LEN       (CL),
        .MAX_TRIES      (MT),
        .UNLOCK_CYCLES  (UC),
        .LOCKOUT_CYCLES (LC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_we       (cfg_we),
        .cfg_code     (cfg_code),
        .bit_valid    (bit_valid),
        .bit_in       (bit_in),
        .unlock       (unlock),
        .attempt_fail (attempt_fail),
        .locked_out   (locked_out),
        .tries_left   (tries_left)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        cfg_we    = 1'b0;
        cfg_code  = 4'b0000;
    endtask

    task automatic write_cfg(input logic [CL-1:0] code);
        cfg_we   = 1'b1;
        cfg_code = code;
        tick();
        drive_idle();
        m_code = code;
    endtask

    // Shift a code in MSB first; cfg_at >= 0 inserts an ignored config pulse mid-entry
    task automatic enter_bits(input logic [CL-1:0] code, input int cfg_at);
        for (int i = CL - 1; i >= 0; i--) begin
            if (i == cfg_at) begin
                bit_valid = 1'b0;
                cfg_we    = 1'b1;
                cfg_code  = ~code;
                tick();
                cfg_we    = 1'b0;
            end
            bit_valid = 1'b1;
            bit_in    = code[i];
            tick();
        end
        drive_idle();
    endtask

    // One full attempt: enter code, then check the response window cycle by cycle
    task automatic run_attempt(input logic [CL-1:0] code, input bit noise, input int cfg_at, input string tag);
        bit         match;
        bit         lock;
        int         hold;
        int         last;
        logic       exp_unlock;
        logic       exp_lock;
        logic       exp_fail;
        logic [1:0] exp_tries;
        enter_bits(code, cfg_at);
        match = (code == m_code);
        lock  = 1'b0;
        if (match) begin
            m_tries = MT;
            hold    = UC;
        end else begin
            m_tries = m_tries - 1;
            lock    = (m_tries == 0);
            hold    = lock ? LC : 0;
        end
        last = (hold + 1 > 2) ? hold + 1 : 2;
        for (int k = 1; k <= last; k++) begin
            if (noise && (k <= hold + 1)) begin
                bit_valid = 1'($urandom_range(0, 1));
                bit_in    = 1'($urandom);
                cfg_we    = 1'($urandom_range(0, 1));
                cfg_code  = 4'($urandom);
            end else begin
                drive_idle();
            end
            tick();
            exp_unlock = match && (k <= hold);
            exp_lock   = lock && (k <= hold);
            exp_fail   = !match && (k == 1);
            exp_tries  = (lock && (k > hold)) ? 2'(MT) : 2'(m_tries);
            checks += 4;
            if (unlock !== exp_unlock) begin
                errors++;
                $display("FAIL %s unlock cycle %0d: got %b expected %b", tag, k, unlock, exp_unlock);
            end
            if (locked_out !== exp_lock) begin
                errors++;
                $display("FAIL %s locked_out cycle %0d: got %b expected %b", tag, k, locked_out, exp_lock);
            end
            if (attempt_fail !== exp_fail) begin
                errors++;
                $display("FAIL %s attempt_fail cycle %0d: got %b expected %b", tag, k, attempt_fail, exp_fail);
            end
            if (tries_left !== exp_tries) begin
                errors++;
                $display("FAIL %s tries_left cycle %0d: got %0d expected %0d", tag, k, tries_left, exp_tries);
            end
        end
        drive_idle();
        if (lock) m_tries = MT;
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1'b0;
        tick();
        tick();
        checks += 4;
        if (unlock !== 1'b0) begin errors++; $display("FAIL reset unlock: got %b expected 0", unlock); end
        if (locked_out !== 1'b0) begin errors++; $display("FAIL reset locked_out: got %b expected 0", locked_out); end
        if (attempt_fail !== 1'b0) begin errors++; $display("FAIL reset attempt_fail: got %b expected 0", attempt_fail); end
        if (tries_left !== 2'(MT)) begin errors++; $display("FAIL reset tries_left: got %0d expected %0d", tries_left, MT); end
        reset = 1'b1;
        tick();
        m_code  = 4'b0000;
        m_tries = MT;
    endtask

    task automatic test_default_code();
        run_attempt(4'b0000, 1'b0, -1, "default_code");
    endtask

    task automatic test_cfg_match();
        write_cfg(4'b1011);
        run_attempt(4'b1011, 1'b0, -1, "cfg_match");
        run_attempt(4'b1010, 1'b0, -1, "cfg_mismatch");
    endtask

    task automatic test_lockout();
        run_attempt(m_code, 1'b0, -1, "lockout_restore");
        run_attempt(4'b0000, 1'b1, -1, "lockout_wrong1");
        run_attempt(4'b0001, 1'b1, -1, "lockout_wrong2");
        run_attempt(4'b1111, 1'b1, -1, "lockout_wrong3");
        run_attempt(m_code, 1'b0, -1, "lockout_after");
    endtask

    task automatic test_cfg_rules();
        run_attempt(m_code, 1'b0, 1, "cfg_mid_entry");
        cfg_we    = 1'b1;
        cfg_code  = 4'b0110;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        drive_idle();
        m_code = 4'b0110;
        run_attempt(4'b0110, 1'b0, -1, "cfg_beats_bit");
    endtask

    task automatic test_async_reset();
        write_cfg(4'b1001);
        enter_bits(4'b1001, -1);
        tick();
        tick();
        tick();
        checks++;
        if (unlock !== 1'b1) begin errors++; $display("FAIL rst_unlock pre unlock: got %b expected 1", unlock); end
        #2 reset = 1'b0;
        #1;
        checks += 2;
        if (unlock !== 1'b0) begin errors++; $display("FAIL rst_unlock unlock: got %b expected 0", unlock); end
        if (tries_left !== 2'(MT)) begin errors++; $display("FAIL rst_unlock tries_left: got %0d expected %0d", tries_left, MT); end
        tick();
        reset   = 1'b1;
        m_code  = 4'b0000;
        m_tries = MT;
        tick();
        run_attempt(4'b0101, 1'b0, -1, "rst_lock_wrong1");
        run_attempt(4'b0110, 1'b0, -1, "rst_lock_wrong2");
        enter_bits(4'b0111, -1);
        for (int k = 0; k < 6; k++) tick();
        checks += 2;
        if (locked_out !== 1'b1) begin errors++; $display("FAIL rst_lock pre locked_out: got %b expected 1", locked_out); end
        if (tries_left !== 2'd0) begin errors++; $display("FAIL rst_lock pre tries_left: got %0d expected 0", tries_left); end
        #2 reset = 1'b0;
        #1;
        checks += 4;
        if (locked_out !== 1'b0) begin errors++; $display("FAIL rst_lock locked_out: got %b expected 0", locked_out); end
        if (unlock !== 1'b0) begin errors++; $display("FAIL rst_lock unlock: got %b expected 0", unlock); end
        if (attempt_fail !== 1'b0) begin errors++; $display("FAIL rst_lock attempt_fail: got %b expected 0", attempt_fail); end
        if (tries_left !== 2'(MT)) begin errors++; $display("FAIL rst_lock tries_left: got %0d expected %0d", tries_left, MT); end
        tick();
        reset   = 1'b1;
        m_code  = 4'b0000;
        m_tries = MT;
        tick();
        run_attempt(4'b0000, 1'b0, -1, "rst_code_zero");
    endtask

    task automatic test_recover();
        write_cfg(4'b1100);
        run_attempt(4'b0011, 1'b0, -1, "recover_wrong1");
        run_attempt(4'b1101, 1'b0, -1, "recover_wrong2");
        run_attempt(4'b1100, 1'b0, -1, "recover_right");
    endtask

    task automatic test_random();
        logic [CL-1:0] code;
        int            cfg_at;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) write_cfg(4'($urandom));
            code   = ($urandom_range(0, 1) == 1) ? m_code : 4'($urandom);
            cfg_at = ($urandom_range(0, 2) == 0) ? $urandom_range(0, CL - 2) : -1;
            run_attempt(code, 1'b1, cfg_at, "random");
        end
    endtask

    initial begin
        test_reset();
        test_default_code();
        test_cfg_match();
        test_lockout();
        test_cfg_rules();
        test_async_reset();
        test_recover();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
